gecko_print_arbiter: RTL

//   Merges the byte print streams of NUM_CHANNELS gecko_compute instances into one tagged print stream.

---
 rtl/gecko_print_arbiter_pkg.sv | 18 +
 rtl/gecko_print_arbiter_if.sv | 27 ++
 rtl/gecko_print_arbiter_fifo.sv | 50 +++++
 rtl/gecko_print_arbiter.sv | 127 ++++++++++++
 4 files changed

// File: rtl/gecko_print_arbiter_pkg.sv
// rtl/gecko_print_arbiter_pkg.sv - shared types for the gecko print stream arbiter
package gecko_print_arbiter_pkg;

  localparam int GECKO_PRINT_DATA_W = 8;
  localparam int GECKO_PRINT_CH_W   = 2;

  typedef struct packed {
    logic [GECKO_PRINT_DATA_W-1:0] data;
    logic [GECKO_PRINT_CH_W-1:0]   channel;
    logic                          last;
  } gecko_print_beat_t;

  typedef enum logic {
    GECKO_PRINT_IDLE,
    GECKO_PRINT_GRANT
  } gecko_print_state_t;

endpackage

// File: rtl/gecko_print_arbiter_if.sv
// rtl/gecko_print_arbiter_if.sv - per-channel input streams and merged tagged output stream
interface gecko_print_arbiter_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 8
);
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic [NUM_CHANNELS-1:0]                 in_valid;
  logic [NUM_CHANNELS-1:0]                 in_ready;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] in_data;
  logic                                    out_valid;
  logic                                    out_ready;
  logic [DATA_WIDTH-1:0]                   out_data;
  logic [CH_W-1:0]                         out_channel;
  logic                                    out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_channel, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_channel, out_last
  );

endinterface

// File: rtl/gecko_print_arbiter_fifo.sv
// rtl/gecko_print_arbiter_fifo.sv - flop-based per-channel FIFO with head-valid read port
module gecko_print_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic                  do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Power-of-2 depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gecko_print_arbiter.sv
// rtl/gecko_print_arbiter.sv - merges per-channel print streams into one tagged stream, whole lines at a time
module gecko_print_arbiter
  import gecko_print_arbiter_pkg::*;
#(
  parameter int         NUM_CHANNELS    = 4,
  parameter int         DATA_WIDTH      = 8,
  parameter int         FIFO_DEPTH      = 16,
  parameter logic [7:0] LINE_TERMINATOR = 8'h0A,
  parameter int         MAX_LINE_BEATS  = 64,
  parameter int         IDLE_TIMEOUT    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  gecko_print_arbiter_if.slave  bus,
  output logic                  busy
);
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int BW   = $clog2(MAX_LINE_BEATS + 1);
  localparam int IW   = $clog2(IDLE_TIMEOUT + 1);

  logic [NUM_CHANNELS-1:0] push, pop, full, empty;
  logic [DATA_WIDTH-1:0]   head [NUM_CHANNELS];

  gecko_print_state_t state, state_next;
  logic [CH_W-1:0]    grant, last_grant, pick, cand;
  logic               found;
  logic [BW-1:0]      beat_cnt;
  logic [IW-1:0]      idle_cnt;
  logic [DATA_WIDTH-1:0] head_g;
  logic               empty_g, hs, is_last;

  assign bus.in_ready = ~full & {NUM_CHANNELS{~rst}};
  assign push         = bus.in_valid & bus.in_ready;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_fifo
    gecko_print_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push[g]),
      .push_data(bus.in_data[g]),
      .pop      (pop[g]),
      .head     (head[g]),
      .full     (full[g]),
      .empty    (empty[g])
    );
  end

  assign head_g  = head[grant];
  assign empty_g = empty[grant];
  assign is_last = (head_g[7:0] == LINE_TERMINATOR) || (beat_cnt == BW'(MAX_LINE_BEATS - 1));
  assign hs      = (state == GECKO_PRINT_GRANT) && !empty_g && bus.out_ready;
  assign busy    = (|(~empty)) || (state != GECKO_PRINT_IDLE);

  // Round-robin scan starting just after the most recent grant.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_CHANNELS; i++) begin
      cand = CH_W'((int'(last_grant) + i) % NUM_CHANNELS);
      if (!found && !empty[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= GECKO_PRINT_IDLE;
      grant      <= '0;
      last_grant <= CH_W'(NUM_CHANNELS - 1);
      beat_cnt   <= '0;
      idle_cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == GECKO_PRINT_IDLE && found) begin
        grant      <= pick;
        last_grant <= pick;
        beat_cnt   <= '0;
        idle_cnt   <= '0;
      end else if (state == GECKO_PRINT_GRANT) begin
        if (hs) begin
          beat_cnt <= beat_cnt + BW'(1);
          idle_cnt <= '0;
        end else if (empty_g) begin
          idle_cnt <= idle_cnt + IW'(1);
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      GECKO_PRINT_IDLE: begin
        if (found) state_next = GECKO_PRINT_GRANT;
      end
      GECKO_PRINT_GRANT: begin
        if (hs && is_last)
          state_next = GECKO_PRINT_IDLE;
        else if (empty_g && idle_cnt == IW'(IDLE_TIMEOUT - 1))
          state_next = GECKO_PRINT_IDLE;
      end
      default: state_next = GECKO_PRINT_IDLE;
    endcase
  end

  always_comb begin
    bus.out_valid   = 1'b0;
    bus.out_data    = '0;
    bus.out_channel = '0;
    bus.out_last    = 1'b0;
    pop             = '0;
    if (state == GECKO_PRINT_GRANT) begin
      bus.out_valid   = !empty_g;
      bus.out_data    = head_g;
      bus.out_channel = grant;
      bus.out_last    = !empty_g && is_last;
      pop[grant]      = hs;
    end
  end

endmodule
